// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the MEM-stage Wishbone load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] encodes access width for both loads and stores.
   function automatic logic [3:0] calc_sel(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   calc_sel = 4'b0001 << addr_lo;
         2'b01:   calc_sel = 4'b0011 << addr_lo;
         default: calc_sel = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store steering/sel/legality on the request side,
// lane extraction and sign/zero extension on the load-return side.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        st_we,
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_sel,
   output logic [31:0] st_bus_data,
   output logic        st_err,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_bus_data,
   output logic [31:0] ld_data
);

   logic        legal;
   logic        misaligned;
   logic [31:0] shifted;

   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      case (st_funct3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = !st_we;
         default:          legal = 1'b0;
      endcase
      case (st_funct3[1:0])
         2'b01:   misaligned = st_addr_lo[0];
         2'b10:   misaligned = (st_addr_lo != 2'b00);
         default: misaligned = 1'b0;
      endcase
      st_err = !legal || misaligned;
      st_sel = calc_sel(st_funct3, st_addr_lo);
   end

   // Replicating the low bits onto every lane lets sel alone pick the target bytes.
   always_comb begin
      case (st_funct3[1:0])
         2'b00:   st_bus_data = {4{st_wdata[7:0]}};
         2'b01:   st_bus_data = {2{st_wdata[15:0]}};
         default: st_bus_data = st_wdata;
      endcase
   end

   always_comb begin
      shifted = ld_bus_data >> {ld_addr_lo, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ld_data = ld_bus_data;
      endcase
   end

endmodule

// File: rtl/lsu_wb_master.sv
// Wishbone B4 pipelined single-beat initiator for the MEM stage, one op outstanding.
// Handshake: an op is taken on a clk edge where req_valid && req_ready; rsp_valid is a one-cycle pulse.
module lsu_wb_master
   import lsu_pkg::*;
#(
   parameter int AW      = 20,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   input  logic [2:0]    req_funct3,
   input  logic [4:0]    req_rd,
   output logic          rsp_valid,
   output logic [31:0]   rsp_data,
   output logic [4:0]    rsp_rd,
   output logic          rsp_err,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-3:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   output logic [3:0]    o_wb_sel,
   input  logic          i_wb_ack,
   input  logic          i_wb_stall,
   input  logic [31:0]   i_wb_data,
   output state_t        dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   logic          started_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    lo_q;
   logic [4:0]    rd_q;

   logic          cyc_d, stb_d;
   logic          op_load, bus_load, rsp_set, rsp_clr;
   logic [31:0]   rsp_data_d;
   logic [4:0]    rsp_rd_d;
   logic          rsp_err_d;
   logic          accept;

   logic [3:0]    st_sel;
   logic [31:0]   st_bus_data;
   logic          st_err;
   logic [31:0]   ld_data;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:AW];

   lsu_align u_align (
      .st_we       (req_we),
      .st_funct3   (req_funct3),
      .st_addr_lo  (req_addr[1:0]),
      .st_wdata    (req_wdata),
      .st_sel      (st_sel),
      .st_bus_data (st_bus_data),
      .st_err      (st_err),
      .ld_funct3   (f3_q),
      .ld_addr_lo  (lo_q),
      .ld_bus_data (i_wb_data),
      .ld_data     (ld_data)
   );

   // started_q keeps req_ready low until the first edge after reset release.
   assign req_ready = started_q && (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign accept    = req_valid && req_ready;
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cyc_d      = o_wb_cyc;
      stb_d      = o_wb_stb;
      op_load    = 1'b0;
      bus_load   = 1'b0;
      rsp_set    = 1'b0;
      rsp_clr    = 1'b0;
      rsp_data_d = '0;
      rsp_rd_d   = '0;
      rsp_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_load = 1'b1;
               if (st_err) begin
                  rsp_set   = 1'b1;
                  rsp_err_d = 1'b1;
                  rsp_rd_d  = req_we ? 5'd0 : req_rd;
                  state_d   = ST_RESP;
               end else begin
                  bus_load = 1'b1;
                  cyc_d    = 1'b1;
                  stb_d    = 1'b1;
                  state_d  = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (!i_wb_stall) begin
               stb_d = 1'b0;
               cnt_d = '0;
               if (i_wb_ack) begin
                  cyc_d      = 1'b0;
                  rsp_set    = 1'b1;
                  rsp_data_d = we_q ? 32'd0 : ld_data;
                  rsp_rd_d   = we_q ? 5'd0 : rd_q;
                  state_d    = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (i_wb_ack) begin
               cyc_d      = 1'b0;
               rsp_set    = 1'b1;
               rsp_data_d = we_q ? 32'd0 : ld_data;
               rsp_rd_d   = we_q ? 5'd0 : rd_q;
               state_d    = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               cyc_d     = 1'b0;
               rsp_set   = 1'b1;
               rsp_err_d = 1'b1;
               rsp_rd_d  = we_q ? 5'd0 : rd_q;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            rsp_clr = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         started_q <= 1'b0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         lo_q      <= 2'd0;
         rd_q      <= 5'd0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= 32'd0;
         o_wb_sel  <= 4'd0;
         rsp_data  <= 32'd0;
         rsp_rd    <= 5'd0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
         cnt_q     <= cnt_d;
         o_wb_cyc  <= cyc_d;
         o_wb_stb  <= stb_d;
         if (op_load) begin
            we_q <= req_we;
            f3_q <= req_funct3;
            lo_q <= req_addr[1:0];
            rd_q <= req_rd;
         end
         if (bus_load) begin
            o_wb_we   <= req_we;
            o_wb_addr <= req_addr[AW-1:2];
            o_wb_data <= st_bus_data;
            o_wb_sel  <= st_sel;
         end
         if (rsp_set) begin
            rsp_data <= rsp_data_d;
            rsp_rd   <= rsp_rd_d;
            rsp_err  <= rsp_err_d;
         end else if (rsp_clr) begin
            rsp_data <= 32'd0;
            rsp_rd   <= 5'd0;
            rsp_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed bench for lsu_wb_master: vector table of load/store ops against a small
// Wishbone responder memory, plus hand sequences for reset release and reset mid-WAIT.
module tb_lsu_wb_master;
   import lsu_pkg::*;

   localparam int AW      = 20;
   localparam int TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic [2:0]    req_funct3 = '0;
   logic [4:0]    req_rd = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic [4:0]    rsp_rd;
   logic          rsp_err;
   logic          o_wb_cyc, o_wb_stb, o_wb_we;
   logic [AW-3:0] o_wb_addr;
   logic [31:0]   o_wb_data;
   logic [3:0]    o_wb_sel;
   logic          i_wb_ack = 1'b0;
   logic          i_wb_stall = 1'b0;
   logic [31:0]   i_wb_data = '0;
   state_t        dbg_state;

   lsu_wb_master #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_funct3(req_funct3), .req_rd(req_rd),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          stall;
      bit          withhold;
      bit          exp_bus;
      logic [3:0]  exp_sel;
      logic [31:0] exp_bdata;
      logic [31:0] exp_data;
      logic        exp_err;
      logic [4:0]  exp_rd;
      int          exp_lat;
      string       name;
   } vec_t;

   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem[256];
   vec_t        vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input int stall,
                               input bit withhold, input bit exp_bus, input logic [3:0] exp_sel,
                               input logic [31:0] exp_bdata, input logic [31:0] exp_data,
                               input logic exp_err, input logic [4:0] exp_rd, input int exp_lat,
                               input string name);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.stall = stall;
      v.withhold = withhold; v.exp_bus = exp_bus; v.exp_sel = exp_sel; v.exp_bdata = exp_bdata;
      v.exp_data = exp_data; v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
      v.name = name;
      return v;
   endfunction

   // driver + responder: issues one op, plays the Wishbone responder, checks the response
   task automatic run_op(input vec_t v);
      int          stall_left = v.stall;
      int          stb_cycles = 0;
      int          accepts = 0;
      int          wait_cycles = 0;
      int          lat = 0;
      int          ack_idx = 0;
      bit          pend = 0;
      bit          done = 0;
      bit          seen = 0;
      bit          unstable = 0;
      logic [3:0]  sel0 = '0;
      logic [31:0] dat0 = '0;
      logic [AW-3:0] adr0 = '0;
      logic        we0 = 1'b0;
      logic [31:0] exp_d;

      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      req_funct3 = v.f3; req_rd = v.rd;
      check({v.name, ".ready"}, 32'(req_ready), 32'd1);
      exp_q.push_back(v.exp_data);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         if (c > 1) @(negedge clk);
         i_wb_ack = 1'b0;
         i_wb_data = '0;
         if (pend) begin
            i_wb_ack = 1'b1;
            i_wb_data = mem[ack_idx];
            pend = 0;
         end
         if (rsp_valid) begin
            done = 1;
            lat = c;
            check({v.name, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
            check({v.name, ".rsp_rd"}, 32'(rsp_rd), 32'(v.exp_rd));
            if (exp_q.size() == 0) begin
               check({v.name, ".exp_q_empty"}, 32'd1, 32'd0);
            end else begin
               exp_d = exp_q.pop_front();
               check({v.name, ".rsp_data"}, rsp_data, exp_d);
            end
         end else begin
            if (o_wb_cyc && !o_wb_stb) wait_cycles++;
            if (o_wb_stb) begin
               stb_cycles++;
               if (!seen) begin
                  seen = 1; sel0 = o_wb_sel; dat0 = o_wb_data; adr0 = o_wb_addr; we0 = o_wb_we;
               end else if (o_wb_sel !== sel0 || o_wb_data !== dat0 ||
                            o_wb_addr !== adr0 || o_wb_we !== we0) begin
                  unstable = 1;
               end
               if (stall_left > 0) begin
                  i_wb_stall = 1'b1;
                  stall_left--;
               end else begin
                  i_wb_stall = 1'b0;
                  accepts++;
                  if (!v.withhold) begin
                     pend = 1;
                     ack_idx = int'(o_wb_addr[7:0]);
                     if (o_wb_we)
                        for (int l = 0; l < 4; l++)
                           if (o_wb_sel[l]) mem[ack_idx][8*l +: 8] = o_wb_data[8*l +: 8];
                  end
               end
            end else begin
               i_wb_stall = 1'b0;
            end
         end
      end
      i_wb_ack = 1'b0;
      i_wb_stall = 1'b0;
      if (!done) begin
         check({v.name, ".rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, ".bus_seen"}, 32'(seen), 32'(v.exp_bus));
      if (v.exp_bus) begin
         check({v.name, ".sel"}, 32'(sel0), 32'(v.exp_sel));
         check({v.name, ".addr"}, 32'(adr0), 32'(v.addr[AW-1:2]));
         check({v.name, ".we"}, 32'(we0), 32'(v.we));
         if (v.we) check({v.name, ".bus_data"}, dat0, v.exp_bdata);
         check({v.name, ".stb_cycles"}, 32'(stb_cycles), 32'(v.stall + 1));
         check({v.name, ".accepts"}, 32'(accepts), 32'd1);
         check({v.name, ".stable"}, 32'(unstable), 32'd0);
         if (v.withhold) check({v.name, ".wait_cycles"}, 32'(wait_cycles), 32'(TIMEOUT));
      end
      @(negedge clk);
      check({v.name, ".pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int rv_seen;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      vecs.push_back(mk(1, F3_W,  32'h100,  32'hDEADBEEF, 5'd1,  0, 0, 1, 4'hF, 32'hDEADBEEF, 32'h0,        0, 5'd0,  3, "sw_100"));
      vecs.push_back(mk(0, F3_W,  32'h100,  32'h0,        5'd5,  0, 0, 1, 4'hF, 32'h0,        32'hDEADBEEF, 0, 5'd5,  3, "lw_100"));
      vecs.push_back(mk(1, F3_B,  32'h102,  32'h000000A5, 5'd2,  0, 0, 1, 4'h4, 32'hA5A5A5A5, 32'h0,        0, 5'd0,  3, "sb_102"));
      vecs.push_back(mk(0, F3_B,  32'h102,  32'h0,        5'd6,  0, 0, 1, 4'h4, 32'h0,        32'hFFFFFFA5, 0, 5'd6,  3, "lb_102"));
      vecs.push_back(mk(0, F3_BU, 32'h102,  32'h0,        5'd7,  0, 0, 1, 4'h4, 32'h0,        32'h000000A5, 0, 5'd7,  3, "lbu_102"));
      vecs.push_back(mk(0, F3_H,  32'h1001, 32'h0,        5'd8,  0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 5'd8,  1, "lh_1001_mis"));
      vecs.push_back(mk(0, F3_HU, 32'h102,  32'h0,        5'd9,  3, 0, 1, 4'hC, 32'h0,        32'h0000DEA5, 0, 5'd9,  6, "lhu_102_stall"));
      vecs.push_back(mk(0, F3_H,  32'h100,  32'h0,        5'd10, 0, 0, 1, 4'h3, 32'h0,        32'hFFFFBEEF, 0, 5'd10, 3, "lh_100"));
      vecs.push_back(mk(1, F3_H,  32'h106,  32'h12345678, 5'd3,  0, 0, 1, 4'hC, 32'h56785678, 32'h0,        0, 5'd0,  3, "sh_106"));
      vecs.push_back(mk(0, F3_W,  32'h104,  32'h0,        5'd11, 0, 0, 1, 4'hF, 32'h0,        32'h56780000, 0, 5'd11, 3, "lw_104"));
      vecs.push_back(mk(0, F3_B,  32'h107,  32'h0,        5'd12, 0, 0, 1, 4'h8, 32'h0,        32'h00000056, 0, 5'd12, 3, "lb_107"));
      vecs.push_back(mk(0, F3_BU, 32'h103,  32'h0,        5'd13, 0, 0, 1, 4'h8, 32'h0,        32'h000000DE, 0, 5'd13, 3, "lbu_103"));
      vecs.push_back(mk(0, F3_B,  32'h101,  32'h0,        5'd14, 0, 0, 1, 4'h2, 32'h0,        32'hFFFFFFBE, 0, 5'd14, 3, "lb_101"));
      vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0,        5'd15, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 5'd15, 1, "ld_f3_011"));
      vecs.push_back(mk(1, F3_BU, 32'h100,  32'h1,        5'd16, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 5'd0,  1, "st_f3_100"));
      vecs.push_back(mk(1, F3_W,  32'h102,  32'h0,        5'd0,  0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 5'd0,  1, "sw_102_mis"));
      vecs.push_back(mk(0, F3_W,  32'h100,  32'h0,        5'd17, 0, 1, 1, 4'hF, 32'h0,        32'h0,        1, 5'd17, TIMEOUT + 2, "lw_timeout"));
      vecs.push_back(mk(0, F3_W,  32'h104,  32'h0,        5'd18, 0, 0, 1, 4'hF, 32'h0,        32'h56780000, 0, 5'd18, 3, "lw_after_to"));
      vecs.push_back(mk(0, F3_HU, 32'h106,  32'h0,        5'd19, 0, 0, 1, 4'hC, 32'h0,        32'h00005678, 0, 5'd19, 3, "lhu_106"));

      // reset and release
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({req_ready, rsp_valid, rsp_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}) |
            rsp_data | o_wb_data | 32'(o_wb_addr) | 32'(rsp_rd), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b1;
      #1;
      check("ready_before_first_clk", 32'(req_ready), 32'd0);

      for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

      // reset while waiting for ack
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = F3_W; req_rd = 5'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_wait_bus", 32'({o_wb_cyc, o_wb_stb}), 32'b10);
      #2 reset = 1'b0;
      #1;
      check("reset_drops_bus", 32'({o_wb_cyc, o_wb_stb}), 32'd0);
      rv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) rv_seen++;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) rv_seen++;
      end
      check("no_rsp_after_reset", 32'(rv_seen), 32'd0);
      run_op(mk(0, F3_W, 32'h100, 32'h0, 5'd4, 0, 0, 1, 4'hF, 32'h0, 32'hDEA5BEEF, 0, 5'd4, 3, "lw_after_reset"));

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
